serdesphy_ana_pll_pfd: RTL
==========================

# serdesphy_ana_pll_pfd

Clocked behavioural model of the PLL phase-frequency detector. It samples the reference and divided-feedback clocks in the `clk` domain and runs a tri-state PFD state machine. The machine produces the `up_pulse`/`down_pulse` pair that drives the charge pump directly downstream. The block also measures the phase error in `clk` cycles and runs a lock detector that the PLL control logic uses.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `ref_clk_in` and `fb_clk_in`, legal range 2–4.
- `RESET_DELAY`, default 1: number of cycles the CLEAR state holds both pulses high, legal range 1–4.
- `LOCK_WINDOW`, default 2: largest phase error, in cycles, that counts as a good compare.
- `LOCK_COUNT`, default 64: number of consecutive good compares needed to declare lock, legal range 2–255.

Ports:
- `clk`  in  1  model sampling clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  PFD enable; 0 is a synchronous flush.
- `ref_clk_in`  in  1  reference clock, asynchronous to `clk`.
- `fb_clk_in`  in  1  divided VCO feedback clock, asynchronous to `clk`.
- `up_pulse`  out  1  to charge pump UP input.
- `down_pulse`  out  1  to charge pump DOWN input.
- `phase_err_mag`  out  8  magnitude of the last completed compare, in cycles.
- `phase_err_lead`  out  1  1 when ref led fb in the last compare.
- `compare_valid`  out  1  one-cycle strobe when `phase_err_*` update.
- `lock_detect`  out  1  lock indicator.

## Operation
- **Input path:**
  - Each input passes through `SYNC_STAGES` flops, all resetting to 0.
  - One extra history flop per input gives the rising-edge strobes `ref_rise` and `fb_rise`.
  - The synchronizers keep running while `enable`=0.
- **FSM states:** IDLE, UP, DOWN, CLEAR. All states reset to IDLE.
- **IDLE transitions:**
  - `ref_rise` without `fb_rise` → UP.
  - `fb_rise` without `ref_rise` → DOWN.
  - Both in the same cycle → stay in IDLE and complete a compare with magnitude 0, lead 0.
- **UP and DOWN:**
  - UP: `fb_rise` → CLEAR. A repeat `ref_rise` is ignored and the state stays UP. `ref_rise` and `fb_rise` together → CLEAR.
  - DOWN mirrors UP with the roles of `ref_rise` and `fb_rise` swapped.
- **CLEAR:**
  - Stays for exactly `RESET_DELAY` cycles, then enters IDLE.
  - Edges arriving during CLEAR set pending flags.
  - On exit, the pending flags are evaluated with IDLE rules in place of the strobes, then cleared.
- **Output decode:** decoded from the registered state.
  - `up_pulse` is 1 in UP and CLEAR.
  - `down_pulse` is 1 in DOWN and CLEAR.
- **Error counter:**
  - 8-bit counter, cleared on entry to UP or DOWN.
  - Increments every cycle spent in UP or DOWN and saturates at 255.
- **Compare completion:** on UP/DOWN→CLEAR, or on simultaneous edges in IDLE:
  - `phase_err_mag` latches the counter value (0 for simultaneous edges).
  - `phase_err_lead` latches 1 if leaving UP, else 0.
  - `compare_valid` pulses for one cycle.
- **Lock detector:**
  - An 8-bit good counter tracks consecutive good compares.
  - On each completed compare with mag ≤ `LOCK_WINDOW`, the good counter increments, saturating at `LOCK_COUNT`.
  - When the good counter reaches `LOCK_COUNT`, `lock_detect` is set.
  - A compare with mag > `LOCK_WINDOW` clears the good counter and `lock_detect`.
  - The error counter reaching 255 also clears both, even though no compare completes.
- **Enable:**
  - `enable`=0 forces, on the next edge: IDLE, pulses 0, all counters and pending flags 0, `phase_err_*` 0, `lock_detect` 0.
  - Edge strobes are ignored while `enable`=0.

## Timing
- **Reset values:** every output is 0 (`up_pulse`, `down_pulse`, `phase_err_mag`, `phase_err_lead`, `compare_valid`, `lock_detect`).
- **Input-to-pulse latency:** an input rising transition sampled at edge k produces the edge strobe during cycle k+`SYNC_STAGES`. The pulse output changes at edge k+`SYNC_STAGES`+1, which is 3 cycles by default.
- **Pulse width:**
  - `up_pulse` width = N + `RESET_DELAY` cycles, where N is the edge separation in `clk` cycles.
  - Only the final `RESET_DELAY` cycles overlap `down_pulse`.
- **Compare strobe:** `compare_valid` and the updated `phase_err_*` appear at the same edge as entry to CLEAR (or at the IDLE compare edge).
- **Lock update:** `lock_detect` updates one cycle after the qualifying `compare_valid`.
- **Reset mid-operation:** asynchronous return to IDLE with all outputs 0 immediately; no pending state survives.

## Test plan
- Ref leads fb by 5 cycles, defaults → `up_pulse` high 5 cycles, then `up_pulse`=`down_pulse`=1 for 1 cycle; `phase_err_mag`=5, lead=1, one `compare_valid`.
- Fb leads ref by 3 cycles → `down_pulse` high 3 cycles, then 1 overlap cycle; mag=3, lead=0.
- Both edges arrive in the same `clk` cycle → no pulses; `compare_valid` with mag=0, lead=0.
- 64 compares with 1-cycle offset → `lock_detect` rises one cycle after the 64th strobe. A subsequent 3-cycle offset → `lock_detect` falls one cycle after that strobe.
- Ref toggling, fb held at 0 → `up_pulse` stuck high, error counter saturates at 255, `lock_detect` forced to 0, no `compare_valid`.
- Assert `rst_n`=0 mid-UP, and separately drop `enable` mid-DOWN with lock held → all outputs 0 (immediately for reset, next edge for enable). After release, the first new compare behaves as from IDLE.

Source files
------------

// File: rtl/serdesphy_ana_pll_pfd.sv
// Clocked behavioural phase-frequency detector: synchronises ref/fb clocks, runs a tri-state
// PFD with a timed CLEAR phase, measures phase error in clk cycles and tracks lock.
module serdesphy_ana_pll_pfd #(
    parameter int SYNC_STAGES = 2,
    parameter int RESET_DELAY = 1,
    parameter int LOCK_WINDOW = 2,
    parameter int LOCK_COUNT  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ref_clk_in,
    input  logic       fb_clk_in,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [7:0] phase_err_mag,
    output logic       phase_err_lead,
    output logic       compare_valid,
    output logic       lock_detect
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_CLEAR
    } pfdState_t;

    localparam logic [1:0] LP_CLR_LAST = 2'(RESET_DELAY - 1);
    localparam logic [7:0] LP_LOCK     = 8'(LOCK_COUNT);

    logic [SYNC_STAGES-1:0] r_refSync;
    logic [SYNC_STAGES-1:0] r_fbSync;
    logic                   r_refHist;
    logic                   r_fbHist;
    logic                   r_refRise;
    logic                   r_fbRise;

    pfdState_t  r_state;
    pfdState_t  w_nextState;
    logic [7:0] r_errCnt;
    logic [1:0] r_clrCnt;
    logic       r_pendRef;
    logic       r_pendFb;
    logic [7:0] r_phaseErrMag;
    logic       r_phaseErrLead;
    logic       r_compareValid;
    logic [7:0] r_goodCnt;
    logic       r_lockDetect;

    logic       w_refEff;
    logic       w_fbEff;
    logic [7:0] w_errInc;
    logic       w_complete;
    logic [7:0] w_cmpMag;
    logic       w_cmpLead;
    logic       w_exitClear;
    logic       w_inPulse;
    logic       w_errSat;

    // Synchroniser, history flop and registered rising-edge strobes; these never stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refSync <= '0;
            r_fbSync  <= '0;
            r_refHist <= 1'b0;
            r_fbHist  <= 1'b0;
            r_refRise <= 1'b0;
            r_fbRise  <= 1'b0;
        end else begin
            r_refSync <= {r_refSync[SYNC_STAGES-2:0], ref_clk_in};
            r_fbSync  <= {r_fbSync[SYNC_STAGES-2:0], fb_clk_in};
            r_refHist <= r_refSync[SYNC_STAGES-1];
            r_fbHist  <= r_fbSync[SYNC_STAGES-1];
            r_refRise <= r_refSync[SYNC_STAGES-1] & ~r_refHist;
            r_fbRise  <= r_fbSync[SYNC_STAGES-1] & ~r_fbHist;
        end
    end

    // Pending flags are only ever set inside CLEAR, so IDLE rules can use the merged view.
    assign w_refEff  = r_pendRef | r_refRise;
    assign w_fbEff   = r_pendFb | r_fbRise;
    assign w_errInc  = (r_errCnt == 8'hFF) ? 8'hFF : r_errCnt + 8'd1;
    assign w_inPulse = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign w_errSat  = w_inPulse && (r_errCnt == 8'hFF);

    always_comb begin
        w_nextState = r_state;
        w_complete  = 1'b0;
        w_cmpMag    = 8'd0;
        w_cmpLead   = 1'b0;
        w_exitClear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_refEff && !w_fbEff) begin
                    w_nextState = ST_UP;
                end else if (w_fbEff && !w_refEff) begin
                    w_nextState = ST_DOWN;
                end else if (w_refEff && w_fbEff) begin
                    w_complete = 1'b1;
                end
            end
            ST_UP: begin
                if (r_fbRise) begin
                    w_nextState = ST_CLEAR;
                    w_complete  = 1'b1;
                    w_cmpMag    = w_errInc;
                    w_cmpLead   = 1'b1;
                end
            end
            ST_DOWN: begin
                if (r_refRise) begin
                    w_nextState = ST_CLEAR;
                    w_complete  = 1'b1;
                    w_cmpMag    = w_errInc;
                end
            end
            ST_CLEAR: begin
                if (r_clrCnt == LP_CLR_LAST) begin
                    w_exitClear = 1'b1;
                    w_nextState = ST_IDLE;
                    if (w_refEff && !w_fbEff) begin
                        w_nextState = ST_UP;
                    end else if (w_fbEff && !w_refEff) begin
                        w_nextState = ST_DOWN;
                    end else if (w_refEff && w_fbEff) begin
                        w_complete = 1'b1;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_errCnt       <= 8'd0;
            r_clrCnt       <= 2'd0;
            r_pendRef      <= 1'b0;
            r_pendFb       <= 1'b0;
            r_phaseErrMag  <= 8'd0;
            r_phaseErrLead <= 1'b0;
            r_compareValid <= 1'b0;
            r_goodCnt      <= 8'd0;
            r_lockDetect   <= 1'b0;
        end else if (!enable) begin
            r_state        <= ST_IDLE;
            r_errCnt       <= 8'd0;
            r_clrCnt       <= 2'd0;
            r_pendRef      <= 1'b0;
            r_pendFb       <= 1'b0;
            r_phaseErrMag  <= 8'd0;
            r_phaseErrLead <= 1'b0;
            r_compareValid <= 1'b0;
            r_goodCnt      <= 8'd0;
            r_lockDetect   <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if ((w_nextState == ST_UP || w_nextState == ST_DOWN) && (w_nextState != r_state)) begin
                r_errCnt <= 8'd0;
            end else if (w_inPulse) begin
                r_errCnt <= w_errInc;
            end

            r_clrCnt <= (r_state == ST_CLEAR) ? r_clrCnt + 2'd1 : 2'd0;

            if (r_state == ST_CLEAR && !w_exitClear) begin
                r_pendRef <= r_pendRef | r_refRise;
                r_pendFb  <= r_pendFb | r_fbRise;
            end else begin
                r_pendRef <= 1'b0;
                r_pendFb  <= 1'b0;
            end

            r_compareValid <= w_complete;
            if (w_complete) begin
                r_phaseErrMag  <= w_cmpMag;
                r_phaseErrLead <= w_cmpLead;
            end

            // Lock follows the registered compare result, so it lags compare_valid by a cycle.
            if (r_compareValid) begin
                if (int'(r_phaseErrMag) <= LOCK_WINDOW) begin
                    if (r_goodCnt >= LP_LOCK - 8'd1) begin
                        r_goodCnt    <= LP_LOCK;
                        r_lockDetect <= 1'b1;
                    end else begin
                        r_goodCnt <= r_goodCnt + 8'd1;
                    end
                end else begin
                    r_goodCnt    <= 8'd0;
                    r_lockDetect <= 1'b0;
                end
            end
            if (w_errSat) begin
                r_goodCnt    <= 8'd0;
                r_lockDetect <= 1'b0;
            end
        end
    end

    assign up_pulse       = (r_state == ST_UP) || (r_state == ST_CLEAR);
    assign down_pulse     = (r_state == ST_DOWN) || (r_state == ST_CLEAR);
    assign phase_err_mag  = r_phaseErrMag;
    assign phase_err_lead = r_phaseErrLead;
    assign compare_valid  = r_compareValid;
    assign lock_detect    = r_lockDetect;

endmodule
